rob_param: RTL
==============

ROB_PARAM -- requirements
Module: rob_param

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count (power of 2, ≥4).
REQ-002 SHALL have parameter XLEN, default 32, data/PC width.
REQ-003 SHALL have parameter NWB, default 2, number of writeback ports.
REQ-004 SHALL define IW = clog2(DEPTH) internally as the entry index width.
REQ-005 SHALL have ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
alloc_valid  in  1  allocate request
alloc_ready  out  1  not full
alloc_idx  out  IW  index allocated this cycle (tail)
alloc_dest  in  5  destination register (0 = none)
alloc_kind  in  2  0 ALU, 1 load, 2 store, 3 branch
alloc_pred  in  1  predicted taken
alloc_pc  in  XLEN  instruction PC
wb_valid  in  NWB  per-port writeback strobe
wb_idx  in  NWB*IW  target entries
wb_value  in  NWB*XLEN  result values
wb_taken  in  NWB  resolved branch direction
wb_target  in  NWB*XLEN  resolved branch target
q_idx  in  2*IW  two operand lookup indices
q_ready  out  2  entry result ready
q_value  out  2*XLEN  entry result
commit_valid  out  1  head retires this cycle
commit_idx  out  IW  retiring index
commit_dest  out  5  retiring destination
commit_value  out  XLEN  retiring value
store_commit  out  1  retiring entry is a store
flush_o  out  1  mispredict flush pulse
redirect_pc  out  XLEN  correct fetch PC
flush_i  in  1  external flush
count  out  IW+1  occupied entries

Function
REQ-006 SHALL hold entries in a circular buffer with head/tail pointers wrapping mod DEPTH.
REQ-007 SHALL assert alloc_ready iff count < DEPTH; alloc occurs on alloc_valid & alloc_ready at clock edge, writing entry with ready=0, tail advancing by 1.
REQ-008 SHALL drive commit_valid combinationally when count>0 and head entry ready; retire occurs at the same edge, head advances by 1.
REQ-009 SHALL update count by +alloc −commit per cycle; simultaneous alloc and commit leave count unchanged; at full, alloc_ready=0 even if commit occurs that cycle.
REQ-010 SHALL apply a writeback only to valid entries, setting value, taken, target, ready=1 at the edge; writebacks to invalid entries are ignored.
REQ-011 SHALL resolve two same-cycle writebacks to one index with the higher port number winning.
REQ-012 SHALL, for a ready branch at head, commit it and assert flush_o if taken≠pred; redirect_pc = target if taken, else pc+4 (XLEN wrap).
REQ-013 SHALL write commit_value to commit_dest only for ALU/load kinds; branches with alloc_dest≠0 (jumps) also report pc+4 as value; store_commit=1 for stores with commit_dest driven 0.
REQ-014 SHALL, on flush_o or flush_i at an edge, clear all valid bits, set head=tail=0, count=0; allocations and writebacks in that cycle are discarded.
REQ-015 SHALL drive q_ready/q_value from registered state for the queried index; q_ready=0 for invalid entries.
REQ-016 SHALL hold all outputs at their reset values and ignore inputs while count=0 except alloc/flush_i.

Reset
REQ-017 SHALL on rst clear all entries, head=tail=0, count=0.
REQ-018 SHALL after reset drive alloc_ready=1, every other output 0; rst overrides flush_i and alloc in the same cycle.

Configuration
REQ-019 SHALL, with macro ROB_WB_BYPASS_EN defined, let q_ready/q_value reflect a same-cycle matching wb_valid port (highest port wins) combinationally; without it, lookups see writebacks one cycle after the edge.

Verification
REQ-020 Reset, alloc 16 ALU ops back-to-back -> alloc_idx 0..15, count=16, alloc_ready=0 on 17th cycle.
REQ-021 Writeback idx 0 value 0x55 on port 0 then commit -> next cycle commit_valid=1, commit_value=0x55, count decrements.
REQ-022 Writeback idx 3 via port 0 value 1 and port 1 value 2 same cycle -> q_value for idx 3 = 2.
REQ-023 Branch at head pred=0, wb_taken=1 target 0x1000 -> flush_o=1, redirect_pc=0x1000, next cycle count=0, head=tail=0.
REQ-024 Fill to 16, commit 3, alloc 3 -> tail wraps to indices 0..2, count=16.
REQ-025 ROB_WB_BYPASS_EN defined, wb idx 5 value 0x9 with q_idx=5 same cycle -> q_ready=1, q_value=0x9 that cycle; undefined -> q_ready=0 until next cycle.

Source files
------------

// File: rtl/rob_if.sv
// Reorder-buffer port bundle: allocate, writeback, lookup, commit and flush.
// The master side feeds instructions/results; the slave side is the ROB.
interface rob_if #(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32,
    parameter int NWB   = 2,
    parameter int IW    = $clog2(DEPTH)
);
    logic                alloc_valid;
    logic                alloc_ready;
    logic [IW-1:0]       alloc_idx;
    logic [4:0]          alloc_dest;
    logic [1:0]          alloc_kind;
    logic                alloc_pred;
    logic [XLEN-1:0]     alloc_pc;
    logic [NWB-1:0]      wb_valid;
    logic [NWB*IW-1:0]   wb_idx;
    logic [NWB*XLEN-1:0] wb_value;
    logic [NWB-1:0]      wb_taken;
    logic [NWB*XLEN-1:0] wb_target;
    logic [2*IW-1:0]     q_idx;
    logic [1:0]          q_ready;
    logic [2*XLEN-1:0]   q_value;
    logic                commit_valid;
    logic [IW-1:0]       commit_idx;
    logic [4:0]          commit_dest;
    logic [XLEN-1:0]     commit_value;
    logic                store_commit;
    logic                flush_o;
    logic [XLEN-1:0]     redirect_pc;
    logic                flush_i;
    logic [IW:0]         count;

    modport master (
        output alloc_valid, alloc_dest, alloc_kind, alloc_pred, alloc_pc,
        output wb_valid, wb_idx, wb_value, wb_taken, wb_target,
        output q_idx, flush_i,
        input  alloc_ready, alloc_idx, q_ready, q_value,
        input  commit_valid, commit_idx, commit_dest, commit_value,
        input  store_commit, flush_o, redirect_pc, count
    );

    modport slave (
        input  alloc_valid, alloc_dest, alloc_kind, alloc_pred, alloc_pc,
        input  wb_valid, wb_idx, wb_value, wb_taken, wb_target,
        input  q_idx, flush_i,
        output alloc_ready, alloc_idx, q_ready, q_value,
        output commit_valid, commit_idx, commit_dest, commit_value,
        output store_commit, flush_o, redirect_pc, count
    );
endinterface

// File: rtl/rob_param.sv
// Parameterised reorder buffer: in-order commit, branch mispredict flush.
// Optional macro ROB_WB_BYPASS_EN forwards same-cycle writebacks to lookups.
module rob_param #(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32,
    parameter int NWB   = 2
) (
    input logic   clk,
    input logic   rst,
    rob_if.slave  bus
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] FULL = (IW+1)'(DEPTH);
    localparam logic [1:0] K_ALU = 2'd0;
    localparam logic [1:0] K_LD  = 2'd1;
    localparam logic [1:0] K_ST  = 2'd2;

    logic [DEPTH-1:0] e_valid;
    logic [DEPTH-1:0] e_ready;
    logic [DEPTH-1:0] e_pred;
    logic [DEPTH-1:0] e_taken;
    logic [1:0]       e_kind   [DEPTH];
    logic [4:0]       e_dest   [DEPTH];
    logic [XLEN-1:0]  e_pc     [DEPTH];
    logic [XLEN-1:0]  e_value  [DEPTH];
    logic [XLEN-1:0]  e_target [DEPTH];

    logic [IW-1:0] head;
    logic [IW-1:0] tail;
    logic [IW:0]   cnt;

    logic            do_alloc;
    logic            do_commit;
    logic            mispred;
    logic            flush;
    logic [XLEN-1:0] pc4;

    // Head retirement, commit reporting and mispredict detection
    always_comb begin
        do_alloc  = bus.alloc_valid && (cnt < FULL);
        do_commit = (cnt != '0) && e_valid[head] && e_ready[head];
        pc4       = e_pc[head] + XLEN'(4);
        mispred   = 1'b0;
        bus.alloc_ready  = cnt < FULL;
        bus.alloc_idx    = tail;
        bus.count        = cnt;
        bus.commit_valid = do_commit;
        bus.commit_idx   = '0;
        bus.commit_dest  = '0;
        bus.commit_value = '0;
        bus.store_commit = 1'b0;
        bus.redirect_pc  = '0;
        if (do_commit) begin
            bus.commit_idx = head;
            unique case (1'b1)
                (e_kind[head] == K_ALU) || (e_kind[head] == K_LD): begin
                    bus.commit_dest  = e_dest[head];
                    bus.commit_value = e_value[head];
                end
                (e_kind[head] == K_ST): begin
                    bus.store_commit = 1'b1;
                end
                default: begin
                    mispred = e_taken[head] != e_pred[head];
                    if (e_dest[head] != '0) begin
                        bus.commit_dest  = e_dest[head];
                        bus.commit_value = pc4;
                    end
                    if (mispred)
                        bus.redirect_pc = e_taken[head] ? e_target[head] : pc4;
                end
            endcase
        end
        bus.flush_o = mispred;
        flush       = mispred || bus.flush_i;
    end

    // Operand lookups from stored state, optionally bypassing writebacks
    always_comb begin
        logic [IW-1:0]   qi;
        logic            rdy;
        logic [XLEN-1:0] val;
        bus.q_ready = '0;
        bus.q_value = '0;
        for (int q = 0; q < 2; q++) begin
            qi  = bus.q_idx[q*IW +: IW];
            rdy = e_valid[qi] && e_ready[qi];
            val = rdy ? e_value[qi] : '0;
`ifdef ROB_WB_BYPASS_EN
            for (int p = 0; p < NWB; p++) begin
                if (bus.wb_valid[p] && e_valid[qi] &&
                    bus.wb_idx[p*IW +: IW] == qi) begin
                    rdy = 1'b1;
                    val = bus.wb_value[p*XLEN +: XLEN];
                end
            end
`endif
            bus.q_ready[q] = rdy;
            bus.q_value[q*XLEN +: XLEN] = val;
        end
    end

    // Entry state, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            e_valid <= '0;
            e_ready <= '0;
            e_pred  <= '0;
            e_taken <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_kind[i]   <= '0;
                e_dest[i]   <= '0;
                e_pc[i]     <= '0;
                e_value[i]  <= '0;
                e_target[i] <= '0;
            end
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            e_valid <= '0;
            e_ready <= '0;
        end else begin
            for (int p = 0; p < NWB; p++) begin
                if (bus.wb_valid[p] && e_valid[bus.wb_idx[p*IW +: IW]]) begin
                    e_ready[bus.wb_idx[p*IW +: IW]]  <= 1'b1;
                    e_taken[bus.wb_idx[p*IW +: IW]]  <= bus.wb_taken[p];
                    e_value[bus.wb_idx[p*IW +: IW]]  <=
                        bus.wb_value[p*XLEN +: XLEN];
                    e_target[bus.wb_idx[p*IW +: IW]] <=
                        bus.wb_target[p*XLEN +: XLEN];
                end
            end
            if (do_alloc) begin
                e_valid[tail] <= 1'b1;
                e_ready[tail] <= 1'b0;
                e_kind[tail]  <= bus.alloc_kind;
                e_dest[tail]  <= bus.alloc_dest;
                e_pred[tail]  <= bus.alloc_pred;
                e_pc[tail]    <= bus.alloc_pc;
                tail          <= tail + IW'(1);
            end
            if (do_commit) begin
                e_valid[head] <= 1'b0;
                head          <= head + IW'(1);
            end
            cnt <= cnt + (IW+1)'(do_alloc) - (IW+1)'(do_commit);
        end
    end
endmodule
